reg_file_wb: RTL and testbench

Writeback stage and register file for the single-issue core. It receives the execute stage's write request (`w_alu`, `w_id`, `w_enable`, `w_select`, destination register, flag update) and registers it into a one-entry writeback slot. On the following edge it commits the slot into an 8×32 register file and a 4-bit CPSR. It also serves the two operand read ports (`r_val_0`, `r_val_1`) and `conditional_flags` back to execute, forwarding from the pending slot so that back-to-back dependent instructions see fresh data.

---
 rtl/reg_file_wb.sv | 92 +++++++++
 tb/tb_reg_file_wb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_wb
// Brief    : One-entry writeback slot feeding an 8x32 register file and CPSR,
//            with slot-to-read-port forwarding.
// Revision : 1.0
// ============================================================================
module reg_file_wb #(
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              w_enable,
   input  logic              w_select,
   input  logic [ADDR_W-1:0] dest_reg,
   input  logic [DATA_W-1:0] w_alu,
   input  logic [DATA_W-1:0] w_id,
   input  logic              flags_we,
   input  logic [3:0]        flags_in,
   input  logic [ADDR_W-1:0] r_addr_0,
   input  logic [ADDR_W-1:0] r_addr_1,
   output logic [DATA_W-1:0] r_val_0,
   output logic [DATA_W-1:0] r_val_1,
   output logic [3:0]        conditional_flags,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [3:0]        r_cpsr;
   logic              r_wb_valid;
   logic [ADDR_W-1:0] r_wb_addr;
   logic [DATA_W-1:0] r_wb_data;
   logic              r_fl_valid;
   logic [3:0]        r_fl_data;
   logic [DATA_W-1:0] w_src_data;

   assign w_src_data = w_select ? w_id : w_alu;

   // Capture of the new request and commit of the old slot share one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_valid <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_data  <= '0;
         r_fl_valid <= 1'b0;
         r_fl_data  <= '0;
      end else if (!stall) begin
         r_wb_valid <= w_enable;
         if (w_enable) begin
            r_wb_addr <= dest_reg;
            r_wb_data <= w_src_data;
         end
         r_fl_valid <= flags_we;
         if (flags_we) begin
            r_fl_data <= flags_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
         r_cpsr <= '0;
      end else if (!stall) begin
         if (r_wb_valid) begin
            r_regs[r_wb_addr] <= r_wb_data;
         end
         if (r_fl_valid) begin
            r_cpsr <= r_fl_data;
         end
      end
   end

   // The pending slot is always younger than the array, so it wins on a hit.
   assign r_val_0 = (r_wb_valid && (r_wb_addr == r_addr_0)) ? r_wb_data : r_regs[r_addr_0];
   assign r_val_1 = (r_wb_valid && (r_wb_addr == r_addr_1)) ? r_wb_data : r_regs[r_addr_1];

   assign conditional_flags = r_fl_valid ? r_fl_data : r_cpsr;

   assign wb_valid = r_wb_valid;
   assign wb_addr  = r_wb_addr;
   assign wb_data  = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_wb
// Brief    : Directed self-checking bench for reg_file_wb with an expected-value queue.
// Revision : 1.0
// ============================================================================
module tb_reg_file_wb;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        w_enable;
   logic        w_select;
   logic [2:0]  dest_reg;
   logic [31:0] w_alu;
   logic [31:0] w_id;
   logic        flags_we;
   logic [3:0]  flags_in;
   logic [2:0]  r_addr_0;
   logic [2:0]  r_addr_1;
   logic [31:0] r_val_0;
   logic [31:0] r_val_1;
   logic [3:0]  conditional_flags;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [31:0] wb_data;

   logic [31:0] exp_q [$];
   int          n_pass;
   int          n_total;

   reg_file_wb #(
      .NUM_REGS(8),
      .ADDR_W  (3),
      .DATA_W  (32)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall            (stall),
      .w_enable         (w_enable),
      .w_select         (w_select),
      .dest_reg         (dest_reg),
      .w_alu            (w_alu),
      .w_id             (w_id),
      .flags_we         (flags_we),
      .flags_in         (flags_in),
      .r_addr_0         (r_addr_0),
      .r_addr_1         (r_addr_1),
      .r_val_0          (r_val_0),
      .r_val_1          (r_val_1),
      .conditional_flags(conditional_flags),
      .wb_valid         (wb_valid),
      .wb_addr          (wb_addr),
      .wb_data          (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] want;
      n_total++;
      if (exp_q.size() == 0) begin
         $error("FAIL %s: observed %h expected <nothing queued>", tag, obs);
      end else begin
         want = exp_q.pop_front();
         assert (obs === want) n_pass++;
         else $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   task automatic drive_write(input logic [2:0] rd, input logic sel,
                              input logic [31:0] alu, input logic [31:0] id);
      w_enable = 1'b1;
      dest_reg = rd;
      w_select = sel;
      w_alu    = alu;
      w_id     = id;
   endtask

   initial begin
      n_pass   = 0;
      n_total  = 0;
      rst_n    = 1'b0;
      stall    = 1'b0;
      w_enable = 1'b0;
      w_select = 1'b0;
      dest_reg = '0;
      w_alu    = '0;
      w_id     = '0;
      flags_we = 1'b0;
      flags_in = '0;
      r_addr_0 = 3'd3;
      r_addr_1 = 3'd6;

      // Reset state
      #2;
      push_exp(32'h0); check("rst_r_val_0", r_val_0);
      push_exp(32'h0); check("rst_r_val_1", r_val_1);
      push_exp(32'h0); check("rst_flags", {28'h0, conditional_flags});
      push_exp(32'h0); check("rst_wb_valid", {31'h0, wb_valid});
      push_exp(32'h0); check("rst_wb_addr", {29'h0, wb_addr});
      push_exp(32'h0); check("rst_wb_data", wb_data);
      #10 rst_n = 1'b1;
      tick();

      // Source mux, ALU path: forwarded then from array
      drive_write(3'd2, 1'b0, 32'h12345678, 32'hFFFF0000);
      r_addr_0 = 3'd2;
      r_addr_1 = 3'd2;
      push_exp(32'h12345678);
      tick();
      check("mux_alu_fwd", r_val_0);
      push_exp(32'h1); check("mux_alu_wb_valid", {31'h0, wb_valid});
      w_enable = 1'b0;
      push_exp(32'h12345678);
      tick();
      check("mux_alu_array", r_val_0);
      push_exp(32'h12345678); check("mux_alu_array_p1", r_val_1);
      push_exp(32'h0); check("mux_alu_idle_valid", {31'h0, wb_valid});

      // Source mux, decode path
      drive_write(3'd2, 1'b1, 32'h12345678, 32'hFFFF0000);
      push_exp(32'hFFFF0000);
      tick();
      check("mux_id_fwd", r_val_0);
      w_enable = 1'b0;
      push_exp(32'hFFFF0000);
      tick();
      check("mux_id_array", r_val_0);

      // Back-to-back writes to r5
      r_addr_0 = 3'd5;
      drive_write(3'd5, 1'b0, 32'h1, 32'h0);
      push_exp(32'h1);
      tick();
      check("b2b_first", r_val_0);
      drive_write(3'd5, 1'b0, 32'h2, 32'h0);
      push_exp(32'h2);
      tick();
      check("b2b_second", r_val_0);
      w_enable = 1'b0;
      push_exp(32'h2);
      tick();
      check("b2b_array", r_val_0);

      // r0 is an ordinary writable register
      drive_write(3'd0, 1'b0, 32'hCAFEF00D, 32'h0);
      tick();
      w_enable = 1'b0;
      tick();
      r_addr_0 = 3'd0;
      r_addr_1 = 3'd0;
      #1;
      push_exp(32'hCAFEF00D); check("r0_p0", r_val_0);
      push_exp(32'hCAFEF00D); check("r0_p1", r_val_1);

      // Stall holds the slot and ignores the presented write
      r_addr_0 = 3'd7;
      drive_write(3'd7, 1'b0, 32'hA5A5A5A5, 32'h0);
      push_exp(32'hA5A5A5A5);
      tick();
      check("stall_capture", r_val_0);
      stall = 1'b1;
      drive_write(3'd7, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         push_exp(32'hA5A5A5A5);
         push_exp(32'h1);
         push_exp(32'hA5A5A5A5);
         tick();
         check("stall_r_val_0", r_val_0);
         check("stall_wb_valid", {31'h0, wb_valid});
         check("stall_wb_data", wb_data);
      end
      stall    = 1'b0;
      w_enable = 1'b0;
      push_exp(32'hA5A5A5A5);
      push_exp(32'h0);
      tick();
      check("stall_array", r_val_0);
      check("stall_release_valid", {31'h0, wb_valid});

      // Flags
      flags_we = 1'b1;
      flags_in = 4'b0010;
      push_exp(32'h2);
      tick();
      check("flags_fwd", {28'h0, conditional_flags});
      flags_we = 1'b0;
      flags_in = 4'b1111;
      push_exp(32'h2);
      tick();
      check("flags_cpsr", {28'h0, conditional_flags});
      push_exp(32'h2);
      tick();
      check("flags_hold", {28'h0, conditional_flags});

      // Dual read of the same register with no write pending
      drive_write(3'd4, 1'b0, 32'h00000080, 32'h0);
      tick();
      w_enable = 1'b0;
      tick();
      r_addr_0 = 3'd4;
      r_addr_1 = 3'd4;
      #1;
      push_exp(32'h80); check("dual_p0", r_val_0);
      push_exp(32'h80); check("dual_p1", r_val_1);
      push_exp(32'h0);  check("dual_wb_valid", {31'h0, wb_valid});

      // Asynchronous reset while the slot holds a write to r3
      r_addr_0 = 3'd3;
      r_addr_1 = 3'd2;
      drive_write(3'd3, 1'b0, 32'hDEADBEEF, 32'h0);
      push_exp(32'hDEADBEEF);
      tick();
      check("mid_rst_pending", r_val_0);
      w_enable = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      push_exp(32'h0); check("mid_rst_r_val_0", r_val_0);
      push_exp(32'h0); check("mid_rst_r_val_1", r_val_1);
      push_exp(32'h0); check("mid_rst_flags", {28'h0, conditional_flags});
      push_exp(32'h0); check("mid_rst_wb_valid", {31'h0, wb_valid});
      push_exp(32'h0); check("mid_rst_wb_addr", {29'h0, wb_addr});
      push_exp(32'h0); check("mid_rst_wb_data", wb_data);
      #3 rst_n = 1'b1;
      push_exp(32'h0);
      tick();
      check("post_rst_r3", r_val_0);
      push_exp(32'h0);
      tick();
      check("post_rst_r3_later", r_val_0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
